// File: rtl/adc_serial_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adc_serial_responder
// Description : Device-side AD7908-style serial ADC responder for loopback.
// Revision    : 1.0
// ============================================================================
module adc_serial_responder #(
    parameter int N      = 12,
    parameter int CHAN_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ADC_CONVST,
    input  logic              ADC_SCK,
    input  logic              ADC_SDI,
    output logic              ADC_SDO,
    input  logic [N-1:0]      sample_data,
    output logic [CHAN_W-1:0] sample_chan,
    output logic [N-1:0]      cfg_word,
    output logic              cfg_valid,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int TX_W   = CHAN_W + N;
    localparam int FALL_W = $clog2(TX_W + 1);
    localparam int RISE_W = $clog2(N + 1);
    localparam int CHAN_LSB = 6;

    localparam logic [FALL_W-1:0] c_last_fall = FALL_W'(TX_W);
    localparam logic [RISE_W-1:0] c_n_rises   = RISE_W'(N);
    localparam logic [RISE_W-1:0] c_last_rise = RISE_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Bit order in the synchronizer vectors: [0] CONVST, [1] SCK, [2] SDI
    logic [2:0]        r_sync_meta;
    logic [2:0]        r_sync;
    logic [1:0]        r_prev;
    logic [N-1:0]      r_conv_reg;
    logic [TX_W-1:0]   r_tx_shift;
    logic [N-2:0]      r_rx_shift;
    logic [FALL_W-1:0] r_fall_cnt;
    logic [RISE_W-1:0] r_rise_cnt;

    logic         w_cs_rise;
    logic         w_cs_fall;
    logic         w_sck_rise;
    logic         w_sck_fall;
    logic         w_sdi;
    logic [N-1:0] w_rx_next;

    assign w_cs_rise  =  r_sync[0] & ~r_prev[0];
    assign w_cs_fall  = ~r_sync[0] &  r_prev[0];
    assign w_sck_rise =  r_sync[1] & ~r_prev[1];
    assign w_sck_fall = ~r_sync[1] &  r_prev[1];
    assign w_sdi      =  r_sync[2];
    assign w_rx_next  = {r_rx_shift, w_sdi};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CONVST edges take priority over any SCK edge seen in the same cycle
    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = S_IDLE;
        end else if (w_cs_fall) begin
            w_state_next = S_SHIFT;
        end else if ((r_state == S_SHIFT) && w_sck_fall && (r_fall_cnt == c_last_fall)) begin
            w_state_next = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
            r_prev      <= '0;
            r_conv_reg  <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_fall_cnt  <= '0;
            r_rise_cnt  <= '0;
            ADC_SDO     <= 1'b0;
            sample_chan <= '0;
            cfg_word    <= '0;
            cfg_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_sync_meta <= {ADC_SDI, ADC_SCK, ADC_CONVST};
            r_sync      <= r_sync_meta;
            r_prev      <= r_sync[1:0];
            cfg_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;

            if (w_cs_rise) begin
                r_conv_reg <= sample_data;
                ADC_SDO    <= 1'b0;
                frame_err  <= (r_state == S_SHIFT);
            end else if (w_cs_fall) begin
                ADC_SDO    <= 1'b0;
                r_tx_shift <= {sample_chan, r_conv_reg};
                r_fall_cnt <= '0;
                r_rise_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                if (w_sck_fall) begin
                    if (r_fall_cnt != c_last_fall) begin
                        ADC_SDO    <= r_tx_shift[TX_W-1];
                        r_tx_shift <= {r_tx_shift[TX_W-2:0], 1'b0};
                        r_fall_cnt <= r_fall_cnt + 1'b1;
                    end else begin
                        ADC_SDO    <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                if (w_sck_rise && (r_rise_cnt < c_n_rises)) begin
                    r_rx_shift <= w_rx_next[N-2:0];
                    r_rise_cnt <= r_rise_cnt + 1'b1;
                    if (r_rise_cnt == c_last_rise) begin
                        cfg_word  <= w_rx_next;
                        cfg_valid <= 1'b1;
                        // WRITE bit set: new channel applies from the next frame's latch
                        if (w_rx_next[N-1]) begin
                            sample_chan <= w_rx_next[CHAN_LSB +: CHAN_W];
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adc_serial_responder
// Description : Directed vector bench for the serial ADC responder.
// Revision    : 1.0
// ============================================================================
module tb_adc_serial_responder;

    logic        clk;
    logic        reset;
    logic        ADC_CONVST;
    logic        ADC_SCK;
    logic        ADC_SDI;
    logic        ADC_SDO;
    logic [11:0] sample_data;
    logic [2:0]  sample_chan;
    logic [11:0] cfg_word;
    logic        cfg_valid;
    logic        frame_done;
    logic        frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_cfgv   = 0;
    int cyc      = 0;
    int cfg_cyc  = 0;
    int done_cyc = 0;

    adc_serial_responder #(.N(12), .CHAN_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .ADC_CONVST  (ADC_CONVST),
        .ADC_SCK     (ADC_SCK),
        .ADC_SDI     (ADC_SDI),
        .ADC_SDO     (ADC_SDO),
        .sample_data (sample_data),
        .sample_chan (sample_chan),
        .cfg_word    (cfg_word),
        .cfg_valid   (cfg_valid),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cfg_valid)  begin n_cfgv <= n_cfgv + 1; cfg_cyc  <= cyc; end
        if (frame_done) begin n_done <= n_done + 1; done_cyc <= cyc; end
        if (frame_err)  n_err <= n_err + 1;
    end

    typedef struct {
        logic [11:0] data;
        logic [11:0] sdi;
        int          nsck;
        logic [15:0] exp_sdo;
        logic [2:0]  exp_chan;
        logic [11:0] exp_cfg;
        int          exp_done;
        int          exp_err;
        int          exp_cfgv;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Master-side frame: CONVST pulse, then nsck SCK cycles of 8 clk; SDO sampled before each rise
    task automatic run_frame(input logic [11:0] data, input logic [11:0] sdi,
                             input int nsck, input int rst_fall, output logic [15:0] bits);
        bits = '0;
        sample_data = data;
        ADC_SDI     = 1'b0;
        ADC_CONVST  = 1'b1;
        repeat (6) @(negedge clk);
        ADC_CONVST = 1'b0;
        repeat (6) @(negedge clk);
        ADC_SDI = sdi[11];
        for (int k = 0; k < nsck; k++) begin
            int idx;
            bits[15-k] = ADC_SDO;
            ADC_SCK = 1'b1;
            repeat (4) @(negedge clk);
            ADC_SCK = 1'b0;
            idx = 10 - k;
            ADC_SDI = (idx >= 0) ? sdi[idx] : 1'b0;
            if (rst_fall == k + 1) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                break;
            end
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] bits;
        logic [2:0]  model_chan;
        logic [2:0]  wr_chan;
        logic [11:0] d;
        logic [11:0] w;
        int          d0, e0, c0, sh;

        tbl[0] = '{12'hA5C, 12'h000, 16, 16'h0A5C, 3'd0, 12'h000, 1, 0, 1};
        tbl[1] = '{12'h123, 12'h9C0, 16, 16'h0123, 3'd7, 12'h9C0, 1, 0, 1};
        tbl[2] = '{12'h456, 12'h040, 16, 16'h7456, 3'd7, 12'h040, 1, 0, 1};
        tbl[3] = '{12'hFFF, 12'h880, 16, 16'h7FFF, 3'd2, 12'h880, 1, 0, 1};
        tbl[4] = '{12'hC3C, 12'h800,  6, 16'h2C3C, 3'd2, 12'h880, 0, 0, 0};
        tbl[5] = '{12'h5A5, 12'h800, 16, 16'h25A5, 3'd0, 12'h800, 1, 1, 1};
        tbl[6] = '{12'h800, 12'h000, 16, 16'h0800, 3'd0, 12'h000, 1, 0, 1};

        reset = 1'b1; ADC_CONVST = 1'b0; ADC_SCK = 1'b0; ADC_SDI = 1'b0; sample_data = '0;
        repeat (4) @(negedge clk);
        check("rst_sdo",   32'(ADC_SDO),     32'h0);
        check("rst_chan",  32'(sample_chan), 32'h0);
        check("rst_cfg",   32'(cfg_word),    32'h0);
        check("rst_cfgv",  32'(cfg_valid),   32'h0);
        check("rst_done",  32'(frame_done),  32'h0);
        check("rst_err",   32'(frame_err),   32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            d0 = n_done; e0 = n_err; c0 = n_cfgv;
            run_frame(tbl[i].data, tbl[i].sdi, tbl[i].nsck, 0, bits);
            sh = 16 - tbl[i].nsck;
            check($sformatf("v%0d_sdo", i),  32'(bits >> sh), 32'(tbl[i].exp_sdo >> sh));
            check($sformatf("v%0d_chan", i), 32'(sample_chan), 32'(tbl[i].exp_chan));
            check($sformatf("v%0d_cfg", i),  32'(cfg_word),    32'(tbl[i].exp_cfg));
            check($sformatf("v%0d_done", i), n_done - d0,      tbl[i].exp_done);
            check($sformatf("v%0d_err", i),  n_err - e0,       tbl[i].exp_err);
            check($sformatf("v%0d_cfgv", i), n_cfgv - c0,      tbl[i].exp_cfgv);
            if (i == 1) check("cfgv_before_done", 32'(cfg_cyc < done_cyc), 32'h1);
        end

        // Select channel 7, then reset on the 9th SCK fall of the following frame
        run_frame(12'h321, 12'h9C0, 16, 0, bits);
        check("pre_rst_chan", 32'(sample_chan), 32'h7);
        d0 = n_done; e0 = n_err;
        run_frame(12'h777, 12'h9C0, 16, 9, bits);
        check("midrst_sdo",  32'(ADC_SDO),     32'h0);
        check("midrst_chan", 32'(sample_chan), 32'h0);
        check("midrst_cfg",  32'(cfg_word),    32'h0);
        check("midrst_done", n_done - d0,      0);
        check("midrst_err",  n_err - e0,       0);
        d0 = n_done; e0 = n_err;
        run_frame(12'hABC, 12'h000, 16, 0, bits);
        check("postrst_sdo",  32'(bits),   32'h0ABC);
        check("postrst_done", n_done - d0, 1);
        check("postrst_err",  n_err - e0,  0);

        // Ping-pong channels 7/0; each frame returns the channel written by the previous one
        model_chan = 3'd0;
        d0 = n_done; e0 = n_err;
        for (int i = 0; i < 256; i++) begin
            wr_chan = (i % 2 == 0) ? 3'd7 : 3'd0;
            d = 12'($urandom);
            w = {1'b1, 2'($urandom), wr_chan, 6'($urandom)};
            run_frame(d, w, 16, 0, bits);
            check($sformatf("pp%0d_sdo", i), 32'(bits), 32'({1'b0, model_chan, d}));
            model_chan = wr_chan;
        end
        check("pp_done", n_done - d0, 256);
        check("pp_err",  n_err - e0,  0);
        check("pp_chan", 32'(sample_chan), 32'(model_chan));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_serial_responder.md
# adc_serial_responder

Synthesizable device-side model of the AD7908-style serial ADC link: responds to the CONVST/SCK/SDI frames issued by the ADC interface and shifts out a leading zero, channel address and N-bit sample on SDO. Sits on the FPGA in place of the physical converter for on-board loopback of the vocoder front end. Sample values come from fabric logic, such as a test-tone generator or the MATLAB vector ROM.

## Interface
- N, 12, sample/config word width
- CHAN_W, 3, channel address width
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- ADC_CONVST  in  1  conversion start from interface; asynchronous to clk phase, synchronized internally
- ADC_SCK  in  1  serial clock from interface; synchronized internally
- ADC_SDI  in  1  config data from interface; master drives on SCK fall, sampled here on SCK rise
- ADC_SDO  out  1  serial data to interface; updated on SCK fall
- sample_data  in  N  value converted for channel sample_chan; latched on CONVST rise
- sample_chan  out  CHAN_W  currently addressed channel
- cfg_word  out  N  last complete config word received
- cfg_valid  out  1  one-cycle pulse when cfg_word updates
- frame_done  out  1  one-cycle pulse after the 16th SCK fall of a frame
- frame_err  out  1  one-cycle pulse on CONVST rise while a frame is incomplete

## Operation
- ADC_CONVST, ADC_SCK and ADC_SDI each pass through a 2-FF synchronizer. Edges are detected on the synchronized copies; SDI is sampled from its synchronized copy at detected SCK rise.
- States: IDLE, SHIFT, DONE.
- Detected CONVST rise, any state:
  - latch sample_data into conv_reg.
  - If in SHIFT: pulse frame_err, go IDLE, leave channel and config unchanged.
  - Otherwise go IDLE.
- Detected CONVST fall, any state:
  - ADC_SDO <= 0 (leading zero).
  - tx_shift <= {sample_chan, conv_reg}, width CHAN_W+N = 15.
  - fall_cnt <= 0, rise_cnt <= 0, go SHIFT.
- SHIFT, detected SCK fall:
  - If fall_cnt < 15: ADC_SDO <= tx_shift MSB, shift left, fall_cnt++.
  - On the 16th fall: ADC_SDO <= 0, pulse frame_done, go DONE.
- SHIFT, detected SCK rise with rise_cnt < N:
  - rx_shift <= {rx_shift[N-2:0], SDI}, rise_cnt++.
  - When rise_cnt reaches N: cfg_word <= rx_shift, pulse cfg_valid.
  - If the new word bit N-1 (WRITE) = 1: sample_chan <= word[8:6], taking effect for the next frame's channel field and latch.
  - Further rises in the frame are ignored.
- DONE and IDLE ignore SCK edges. ADC_SDO holds 0.
- Simultaneous detected CONVST and SCK edges in the same cycle: the CONVST edge wins and the SCK edge is dropped.
- Reset values: ADC_SDO 0, sample_chan 0, cfg_word 0, conv_reg 0, all pulses 0, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame without a frame_err pulse.

## Timing
- Edge detect latency: pin edge to internal action is 3 clk cycles (2 sync + 1 register).
- ADC_SDO changes 3 cycles after each SCK pin fall.
- The SCK high and low phases must each be ≥ 4 clk cycles, so SDO is stable before the master's rising-edge sample. Shorter phases are unsupported.
- sample_data must be stable for ≥ 1 cycle at 3 cycles after the CONVST pin rise.
- cfg_valid and frame_done are single-cycle pulses. cfg_valid precedes frame_done within the same frame.
- Channel update is pipelined by one frame. Frame k returns the channel/data addressed by the config of frame k-1.

## Test plan
- Reset, then CONVST pulse with sample_data=12'hA5C and 16 SCK cycles (8-clk period) -> SDO bits 0,000,1010_0101_1100; frame_done once; frame_err never.
- SDI word 12'b1_0_0_111_000000 in frame 1 -> cfg_valid pulse, cfg_word=12'h9C0, sample_chan=7. Frame 2 returns channel field 111.
- SDI word with WRITE=0 -> cfg_valid pulses; sample_chan unchanged.
- CONVST rise after 6 SCK cycles -> frame_err pulse, sample_chan unchanged. Next frame starts cleanly with a leading 0.
- Reset asserted at SCK fall 9 -> SDO=0, sample_chan=0, state IDLE; no frame_done; next frame is correct.
- Back-to-back frames alternating channels 0/7, as the interface ping-pongs, over 256 frames -> returned channel field and data match a scoreboard delayed by one frame.
